// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD stream driver: widths and FSM state type.
package gcd_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_START,
    S_WAIT,
    S_SEND
  } state_e;

endpackage

// File: rtl/gcd_axis_driver.sv
// AXI-Stream front end for the GCD core: collects (a, b) operand beats,
// drives the core handshake, short-circuits zero operands and returns
// one result beat per pair.
module gcd_axis_driver
  import gcd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              core_start,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_r,
  output logic              err_pair,
  output logic [CNT_W-1:0]  result_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e state;
  logic   tlast_reg;

  // Stream handshake flags are pure decodes of the registered state.
  assign s_axis_tready = (state == S_GET_A) || (state == S_GET_B);
  assign m_axis_tvalid = (state == S_SEND);

  // Pair sequencing FSM with operand, result and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tlast_reg    <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      core_start   <= 1'b0;
      core_a       <= '0;
      core_b       <= '0;
      err_pair     <= 1'b0;
      result_cnt   <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: state <= S_GET_A;

        S_GET_A: begin
          if (s_axis_tvalid) begin
            core_a <= s_axis_tdata;
            // A packet ending on an a beat has no partner; drop it and flag.
            if (s_axis_tlast) begin
              err_pair <= 1'b1;
            end else begin
              state <= S_GET_B;
            end
          end
        end

        S_GET_B: begin
          if (s_axis_tvalid) begin
            core_b    <= s_axis_tdata;
            tlast_reg <= s_axis_tlast;
            // Zero operands would never terminate in the core; answer here.
            if ((core_a == '0) || (s_axis_tdata == '0)) begin
              m_axis_tdata <= core_a | s_axis_tdata;
              m_axis_tlast <= s_axis_tlast;
              state        <= S_SEND;
            end else begin
              state <= S_START;
            end
          end
        end

        S_START: begin
          if (core_ready) begin
            core_start <= 1'b1;
            state      <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (core_done) begin
            m_axis_tdata <= core_r;
            m_axis_tlast <= tlast_reg;
            state        <= S_SEND;
          end
        end

        S_SEND: begin
          if (m_axis_tready) begin
            result_cnt <= result_cnt + CNT_ONE;
            state      <= S_GET_A;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_axis_driver.sv
// Self-checking bench for gcd_axis_driver with a behavioural GCD core.
module tb_gcd_axis_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        core_start;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_ready;
  logic        core_done;
  logic [31:0] core_r;
  logic        err_pair;
  logic [15:0] result_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  // core model controls / state
  int unsigned lat_cfg = 2;
  bit          hold_ready = 1'b0;
  logic        busy;
  int unsigned lat;
  logic [31:0] ca, cb, res;
  int          start_cnt = 0;
  int          stable_err = 0;

  always #5 clk = ~clk;

  gcd_axis_driver #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_ready(core_ready), .core_done(core_done), .core_r(core_r),
    .err_pair(err_pair), .result_cnt(result_cnt)
  );

  // Reference: Euclid by remainder, with the zero-operand rules.
  function automatic logic [31:0] model_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    if (a == 0) return b;
    if (b == 0) return a;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Core model uses binary (Stein) GCD so it is independent of the reference.
  function automatic logic [31:0] core_bin_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    int unsigned sh = 0;
    if (a == 0 || b == 0) return a | b;
    while (((a | b) & 32'd1) == 0) begin
      a = a >> 1; b = b >> 1; sh++;
    end
    while ((a & 32'd1) == 0) a = a >> 1;
    do begin
      while ((b & 32'd1) == 0) b = b >> 1;
      if (a > b) begin t = a; a = b; b = t; end
      b = b - a;
    end while (b != 0);
    return a << sh;
  endfunction

  assign core_ready = !busy && !hold_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      core_done <= 1'b0;
      core_r    <= '0;
      lat       <= 0;
      ca        <= '0;
      cb        <= '0;
      res       <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) start_cnt <= start_cnt + 1;
      if (core_start && !busy) begin
        busy <= 1'b1;
        lat  <= lat_cfg;
        ca   <= core_a;
        cb   <= core_b;
        res  <= core_bin_gcd(core_a, core_b);
      end else if (busy) begin
        if (core_a !== ca || core_b !== cb) stable_err <= stable_err + 1;
        if (lat == 0) begin
          core_done <= 1'b1;
          core_r    <= res;
          busy      <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL s_beat_timeout: tready=%0b required=1", s_axis_tready);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_tvalid();
    int n = 0;
    @(negedge clk);
    while (!m_axis_tvalid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL m_tvalid_timeout: tvalid=%0b required=1", m_axis_tvalid);
    end
  endtask

  // Call at a negedge with tvalid high; consumes exactly one beat.
  task automatic take_result();
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, core_start, err_pair} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got=%b required=00000",
               {s_axis_tready, m_axis_tvalid, m_axis_tlast, core_start, err_pair});
    end
    checks++;
    if ({m_axis_tdata, core_a, core_b, result_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_data: tdata=%0h a=%0h b=%0h cnt=%0d required all 0",
               m_axis_tdata, core_a, core_b, result_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_tready: got=%b required=0", s_axis_tready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL first_tready: got=%b required=1", s_axis_tready);
    end
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    int s0 = start_cnt;
    lat_cfg = 3;
    send_beat(32'd48, 1'b0);
    send_beat(32'd18, 1'b1);
    wait_tvalid();
    checks++;
    if (m_axis_tdata !== 32'd6 || m_axis_tlast !== 1'b1) begin
      failures++;
      $display("FAIL basic_result: tdata=%0d tlast=%b required 6/1", m_axis_tdata, m_axis_tlast);
    end
    checks++;
    if (core_a !== 32'd48 || core_b !== 32'd18) begin
      failures++;
      $display("FAIL basic_operands: a=%0d b=%0d required 48/18", core_a, core_b);
    end
    take_result();
    checks++;
    if (start_cnt - s0 != 1) begin
      failures++;
      $display("FAIL basic_starts: got=%0d required=1", start_cnt - s0);
    end
    checks++;
    if (result_cnt !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL basic_cnt: got=%0d required=%0d", result_cnt, exp_cnt);
    end
  endtask

  task automatic test_zero();
    logic [31:0] za [3] = '{32'd0, 32'd12, 32'd0};
    logic [31:0] zb [3] = '{32'd35, 32'd0, 32'd0};
    int s0 = start_cnt;
    for (int i = 0; i < 3; i++) begin
      send_beat(za[i], 1'b0);
      send_beat(zb[i], 1'(i & 1));
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== model_gcd(za[i], zb[i]) ||
          m_axis_tlast !== 1'(i & 1)) begin
        failures++;
        $display("FAIL zero_pair%0d: tvalid=%b tdata=%0d tlast=%b required 1/%0d/%0d",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, model_gcd(za[i], zb[i]), i & 1);
      end
      take_result();
    end
    checks++;
    if (start_cnt != s0) begin
      failures++;
      $display("FAIL zero_no_start: starts=%0d required=0", start_cnt - s0);
    end
  endtask

  task automatic test_backpressure();
    int c0;
    lat_cfg = 1;
    send_beat(32'd1071, 1'b0);
    send_beat(32'd462, 1'b0);
    wait_tvalid();
    c0 = exp_cnt;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd21 || s_axis_tready !== 1'b0 ||
          result_cnt !== 16'(c0)) begin
        failures++;
        $display("FAIL bp_hold%0d: tvalid=%b tdata=%0d s_tready=%b cnt=%0d required 1/21/0/%0d",
                 i, m_axis_tvalid, m_axis_tdata, s_axis_tready, result_cnt, c0);
      end
      @(negedge clk);
    end
    take_result();
    checks++;
    if (m_axis_tvalid !== 1'b0 || result_cnt !== 16'(c0 + 1)) begin
      failures++;
      $display("FAIL bp_transfer: tvalid=%b cnt=%0d required 0/%0d",
               m_axis_tvalid, result_cnt, c0 + 1);
    end
  endtask

  task automatic test_err_pair();
    send_beat(32'd7, 1'b1);
    @(negedge clk);
    checks++;
    if (err_pair !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL err_flag: err_pair=%b tvalid=%b required 1/0", err_pair, m_axis_tvalid);
    end
    send_beat(32'd9, 1'b0);
    send_beat(32'd6, 1'b1);
    wait_tvalid();
    checks++;
    if (m_axis_tdata !== 32'd3 || m_axis_tlast !== 1'b1 || err_pair !== 1'b1) begin
      failures++;
      $display("FAIL err_result: tdata=%0d tlast=%b err=%b required 3/1/1",
               m_axis_tdata, m_axis_tlast, err_pair);
    end
    take_result();
  endtask

  task automatic test_core_ready_stall();
    int s0 = start_cnt;
    hold_ready = 1'b1;
    send_beat(32'd10, 1'b0);
    send_beat(32'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (core_start !== 1'b0) begin
        failures++;
        $display("FAIL stall_no_start%0d: core_start=%b required=0", i, core_start);
      end
    end
    hold_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (core_start !== 1'b1) begin
      failures++;
      $display("FAIL stall_start_pulse: core_start=%b required=1", core_start);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 1'b0 || start_cnt - s0 != 1) begin
      failures++;
      $display("FAIL stall_single_pulse: core_start=%b starts=%0d required 0/1",
               core_start, start_cnt - s0);
    end
    wait_tvalid();
    checks++;
    if (m_axis_tdata !== 32'd2) begin
      failures++;
      $display("FAIL stall_result: tdata=%0d required=2", m_axis_tdata);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit seen = 1'b0;
    lat_cfg = 20;
    send_beat(32'd100, 1'b0);
    send_beat(32'd75, 1'b1);
    while (!core_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL rstmid_start_timeout: core_start=%b required=1", core_start);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, core_start, err_pair} !== 5'b0 ||
        {m_axis_tdata, core_a, core_b, result_cnt} !== '0) begin
      failures++;
      $display("FAIL rstmid_values: flags=%b tdata=%0h a=%0h b=%0h cnt=%0d required all 0",
               {s_axis_tready, m_axis_tvalid, m_axis_tlast, core_start, err_pair},
               m_axis_tdata, core_a, core_b, result_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    lat_cfg = 3;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rstmid_stale_result: tvalid seen=1 required=0");
    end
    send_beat(32'd8, 1'b0);
    send_beat(32'd12, 1'b0);
    wait_tvalid();
    checks++;
    if (m_axis_tdata !== 32'd4) begin
      failures++;
      $display("FAIL rstmid_result: tdata=%0d required=4", m_axis_tdata);
    end
    take_result();
    checks++;
    if (result_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_cnt: got=%0d required=1", result_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, g;
    logic        last;
    int          s0;
    for (int i = 0; i < 25; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(1, 7) * $urandom_range(1, 3000));
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(1, 7) * $urandom_range(1, 3000));
      if (i == 0) begin a = 32'hFFFF_FFFE; b = 32'h8000_0000; end
      last    = 1'($urandom_range(0, 1));
      lat_cfg = $urandom_range(0, 5);
      g       = model_gcd(a, b);
      s0      = start_cnt;
      send_beat(a, 1'b0);
      send_beat(b, last);
      wait_tvalid();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== g || m_axis_tlast !== last ||
          start_cnt - s0 != ((a == 0 || b == 0) ? 0 : 1)) begin
        failures++;
        $display("FAIL rand%0d: a=%0d b=%0d tvalid=%b tdata=%0d tlast=%b starts=%0d required 1/%0d/%b",
                 i, a, b, m_axis_tvalid, m_axis_tdata, m_axis_tlast, start_cnt - s0, g, last);
      end
      take_result();
      checks++;
      if (result_cnt !== 16'(exp_cnt)) begin
        failures++;
        $display("FAIL rand_cnt%0d: got=%0d required=%0d", i, result_cnt, exp_cnt);
      end
    end
    checks++;
    if (stable_err != 0) begin
      failures++;
      $display("FAIL operand_stability: changes=%0d required=0", stable_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_core_ready_stall();
    test_random();
    test_err_pair();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
